// File: rtl/pulpemu_rst_seq.sv
// pulpemu_rst_seq
//   Reset sequencer for the FPGA emulation top. It waits for the clock to be
//   locked for LOCK_CYCLES consecutive cycles, then releases N_CH active-low
//   resets one at a time, STAGE_CYCLES apart and starting with channel 0. A
//   rising edge on the soft-reset request puts every channel back into reset
//   for SOFT_HOLD_CYCLES and then replays the staged release.
//
// Ports
//   ref_clk        in   1     clock; all logic is rising-edge
//   pad_reset      in   1     synchronous active-high block reset
//   clk_locked_i   in   1     PLL/MMCM lock, already in the ref_clk domain
//   soft_rst_req_i in   1     soft-reset request; only its rising edge acts
//   soft_rst_ack_o out  1     one-cycle pulse when a soft request is accepted
//   rst_n_o        out  N_CH  active-low channel resets (thermometer from bit 0)
//   seq_done_o     out  1     all channels released (state RUN)
//   seq_state_o    out  2     debug: 0 HOLD, 1 RELEASE, 2 RUN, 3 SOFT
module pulpemu_rst_seq #(
    parameter int N_CH             = 4,
    parameter int LOCK_CYCLES      = 1024,
    parameter int STAGE_CYCLES     = 16,
    parameter int SOFT_HOLD_CYCLES = 64
) (
    input  logic            ref_clk,
    input  logic            pad_reset,
    input  logic            clk_locked_i,
    input  logic            soft_rst_req_i,
    output logic            soft_rst_ack_o,
    output logic [N_CH-1:0] rst_n_o,
    output logic            seq_done_o,
    output logic [1:0]      seq_state_o
);

    localparam int MAXC  = (LOCK_CYCLES > STAGE_CYCLES)
                         ? ((LOCK_CYCLES > SOFT_HOLD_CYCLES) ? LOCK_CYCLES : SOFT_HOLD_CYCLES)
                         : ((STAGE_CYCLES > SOFT_HOLD_CYCLES) ? STAGE_CYCLES : SOFT_HOLD_CYCLES);
    localparam int CNT_W = $clog2(MAXC) + 1;
    localparam int STG_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'(LOCK_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAGE_LAST = CNT_W'(STAGE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SOFT_LAST  = CNT_W'(SOFT_HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        RELEASE = 2'd1,
        RUN     = 2'd2,
        SOFT    = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [STG_W-1:0] stage_q, stage_d;
    logic             req_q;
    logic [N_CH-1:0]  rst_n_q, rst_n_d;
    logic             done_q, done_d;
    logic             ack_q, ack_d;
    logic             rise;

    assign rise = soft_rst_req_i & ~req_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stage_d = stage_q;
        rst_n_d = rst_n_q;
        done_d  = done_q;
        ack_d   = 1'b0;

        case (state_q)
            HOLD: begin
                rst_n_d = '0;
                done_d  = 1'b0;
                if (!clk_locked_i) begin
                    cnt_d = '0;
                end else if (cnt_q == LOCK_LAST) begin
                    // Release channel 0 on the qualifying edge itself.
                    cnt_d      = '0;
                    stage_d    = '0;
                    rst_n_d    = '0;
                    rst_n_d[0] = 1'b1;
                    if (N_CH == 1) begin
                        state_d = RUN;
                        done_d  = 1'b1;
                    end else begin
                        state_d = RELEASE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            RELEASE, RUN: begin
                // Lock loss beats a simultaneous request; that rise is dropped.
                if (!clk_locked_i) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                    stage_d = '0;
                    rst_n_d = '0;
                    done_d  = 1'b0;
                end else if (rise) begin
                    state_d = SOFT;
                    cnt_d   = '0;
                    stage_d = '0;
                    rst_n_d = '0;
                    done_d  = 1'b0;
                    ack_d   = 1'b1;
                end else if (state_q == RELEASE) begin
                    if (cnt_q == STAGE_LAST) begin
                        cnt_d   = '0;
                        stage_d = stage_q + 1'b1;
                        // Thermometer: every bit up to and including the next stage.
                        for (int i = 0; i < N_CH; i++)
                            rst_n_d[i] = (i <= int'(stage_q) + 1);
                        if (int'(stage_q) + 1 == N_CH - 1) begin
                            state_d = RUN;
                            done_d  = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            SOFT: begin
                rst_n_d = '0;
                done_d  = 1'b0;
                if (!clk_locked_i) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end else if (cnt_q == SOFT_LAST) begin
                    // Straight back into staged release, no lock requalification.
                    cnt_d      = '0;
                    stage_d    = '0;
                    rst_n_d[0] = 1'b1;
                    if (N_CH == 1) begin
                        state_d = RUN;
                        done_d  = 1'b1;
                    end else begin
                        state_d = RELEASE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: state_d = HOLD;
        endcase
    end

    always_ff @(posedge ref_clk) begin
        if (pad_reset) begin
            state_q <= HOLD;
            cnt_q   <= '0;
            stage_q <= '0;
            req_q   <= 1'b0;
            rst_n_q <= '0;
            done_q  <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stage_q <= stage_d;
            req_q   <= soft_rst_req_i;
            rst_n_q <= rst_n_d;
            done_q  <= done_d;
            ack_q   <= ack_d;
        end
    end

    assign rst_n_o        = rst_n_q;
    assign seq_done_o     = done_q;
    assign soft_rst_ack_o = ack_q;
    assign seq_state_o    = state_q;

endmodule

// File: tb/tb_pulpemu_rst_seq.sv
// Testbench for pulpemu_rst_seq (N_CH=4, LOCK=8, STAGE=4, SOFT_HOLD=6).
// Stimulus pushes the expected output changes (with the edge they must occur
// on) into a queue; a monitor pops one entry each time the DUT outputs change.
module tb_pulpemu_rst_seq;

    logic       clk = 1'b0;
    logic       pad_reset;
    logic       lock;
    logic       req;
    logic       ack;
    logic [3:0] rst_n;
    logic       done;
    logic [1:0] st;

    int cyc    = 0;
    int checks = 0;
    int errs   = 0;
    bit mon_en = 1'b0;

    typedef struct packed {
        int         c;
        logic [3:0] rst;
        logic       done;
        logic       ack;
        logic [1:0] st;
    } ev_t;

    ev_t exp_q[$];
    ev_t prev;
    ev_t cur;

    pulpemu_rst_seq #(
        .N_CH(4), .LOCK_CYCLES(8), .STAGE_CYCLES(4), .SOFT_HOLD_CYCLES(6)
    ) dut (
        .ref_clk        (clk),
        .pad_reset      (pad_reset),
        .clk_locked_i   (lock),
        .soft_rst_req_i (req),
        .soft_rst_ack_o (ack),
        .rst_n_o        (rst_n),
        .seq_done_o     (done),
        .seq_state_o    (st)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every change of the output vector is one observed event.
    always @(negedge clk) begin
        cur = '{c: cyc, rst: rst_n, done: done, ack: ack, st: st};
        if (mon_en && {cur.rst, cur.done, cur.ack, cur.st} !== {prev.rst, prev.done, prev.ack, prev.st}) begin
            ev_t e;
            checks++;
            if (exp_q.size() == 0) begin
                errs++;
                $display("FAIL unexpected_change: got edge=%0d rst_n=%b done=%b ack=%b st=%0d, required no change",
                         cur.c, cur.rst, cur.done, cur.ack, cur.st);
            end else begin
                e = exp_q.pop_front();
                if (cur !== e) begin
                    errs++;
                    $display("FAIL event: got edge=%0d rst_n=%b done=%b ack=%b st=%0d, required edge=%0d rst_n=%b done=%b ack=%b st=%0d",
                             cur.c, cur.rst, cur.done, cur.ack, cur.st, e.c, e.rst, e.done, e.ack, e.st);
                end
            end
        end
        prev = cur;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) step();
    endtask

    task automatic push(input int c, input logic [3:0] r, input logic d, input logic a, input logic [1:0] s);
        exp_q.push_back('{c: c, rst: r, done: d, ack: a, st: s});
    endtask

    // Staged release whose first edge (0001) is e0.
    task automatic exp_release(input int e0);
        push(e0,      4'b0001, 1'b0, 1'b0, 2'd1);
        push(e0 + 4,  4'b0011, 1'b0, 1'b0, 2'd1);
        push(e0 + 8,  4'b0111, 1'b0, 1'b0, 2'd1);
        push(e0 + 12, 4'b1111, 1'b1, 1'b0, 2'd2);
    endtask

    // Issue a soft request seen at edge cyc+1; returns that edge.
    task automatic soft_req(output int n);
        req = 1'b1;
        n   = cyc + 1;
        push(n,     4'b0000, 1'b0, 1'b1, 2'd3);
        push(n + 1, 4'b0000, 1'b0, 1'b0, 2'd3);
    endtask

    // pad_reset for one edge from a running state; returns base (edge 1 = base+1).
    task automatic pad_pulse(output int base);
        pad_reset = 1'b1;
        push(cyc + 1, 4'b0000, 1'b0, 1'b0, 2'd0);
        step();
        pad_reset = 1'b0;
        base = cyc;
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            errs++;
            $display("FAIL %s: got %0d pending events, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        int base;
        int n;
        pad_reset = 1'b1;
        lock      = 1'b0;
        req       = 1'b0;
        repeat (3) step();

        checks++;
        if ({rst_n, done, ack, st} !== 8'b0000_0_0_00) begin
            errs++;
            $display("FAIL reset_state: got rst_n=%b done=%b ack=%b st=%0d, required 0000 0 0 0",
                     rst_n, done, ack, st);
        end
        mon_en = 1'b1;

        // 1: power-up with lock high
        pad_reset = 1'b0;
        lock      = 1'b1;
        base      = cyc;
        exp_release(base + 8);
        wait_to(base + 24);
        check_drained("powerup");

        // 3: soft request from RUN
        soft_req(n);
        exp_release(n + 6);
        step();
        req = 1'b0;
        wait_to(n + 22);
        check_drained("soft_run");

        // 5: request held 30 cycles, only one soft sequence
        soft_req(n);
        exp_release(n + 6);
        wait_to(n + 29);
        req = 1'b0;
        wait_to(n + 36);
        check_drained("soft_held");

        // 6a: pad_reset while in SOFT
        soft_req(n);
        step();
        req = 1'b0;
        wait_to(n + 2);
        pad_reset = 1'b1;
        push(n + 3, 4'b0000, 1'b0, 1'b0, 2'd0);
        step();
        step();
        pad_reset = 1'b0;
        base = cyc;
        exp_release(base + 8);
        wait_to(base + 24);
        check_drained("pad_in_soft");

        // 6b: pad_reset while in RUN
        pad_pulse(base);
        exp_release(base + 8);
        wait_to(base + 24);
        check_drained("pad_in_run");

        // 4: lock loss together with a rise while at 0011
        soft_req(n);
        push(n + 6,  4'b0001, 1'b0, 1'b0, 2'd1);
        push(n + 10, 4'b0011, 1'b0, 1'b0, 2'd1);
        push(n + 11, 4'b0000, 1'b0, 1'b0, 2'd0);
        step();
        req = 1'b0;
        wait_to(n + 10);
        lock = 1'b0;
        req  = 1'b1;
        step();
        lock = 1'b1;
        req  = 1'b0;
        exp_release(n + 19);
        wait_to(n + 35);
        check_drained("lockloss_rise");

        // 2: lock drops at edge 5, returns at edge 6
        pad_pulse(base);
        wait_to(base + 4);
        lock = 1'b0;
        step();
        lock = 1'b1;
        exp_release(base + 13);
        wait_to(base + 30);
        check_drained("lock_glitch");

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    // Hard time limit so the run always ends on its own.
    initial begin
        #100000;
        $display("FAIL timeout: got no completion by 100000, required completion");
        $display("Result: errors=%0d of %0d checks", errs + 1, checks + 1);
        $finish;
    end

endmodule
